// File: rtl/game_state_mp_if.sv
// Control/status bundle between the game-state block and its neighbours:
// key decoder, per-player snake movers and the renderer.
interface game_state_mp_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned LW          = 2
);
  logic                        frame_tick;
  logic                        key_valid;
  logic [7:0]                  key_code;
  logic [NUM_PLAYERS-1:0]      died;
  logic [NUM_PLAYERS-1:0]      init_snake;
  logic                        screen_black;
  logic                        screen_pause;
  logic                        game_over;
  logic [NUM_PLAYERS-1:0]      alive;
  logic [NUM_PLAYERS*LW-1:0]   lives;

  // Environment side: drives events, observes controls.
  modport master (
    output frame_tick, key_valid, key_code, died,
    input  init_snake, screen_black, screen_pause, game_over, alive, lives
  );

  // Game-state block side.
  modport slave (
    input  frame_tick, key_valid, key_code, died,
    output init_snake, screen_black, screen_pause, game_over, alive, lives
  );
endinterface

// File: rtl/game_state_mp.sv
// Multi-player game-state FSM: start/pause keys, per-player lives, a timed
// freeze after each death, selective respawn and a game-over state.
// Every output is a register loaded with the decode of the next state.
module game_state_mp #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned DEATH_HOLD  = 60,
  parameter logic [7:0]  KEY_START   = 8'h29,
  parameter logic [7:0]  KEY_PAUSE   = 8'h4D
) (
  input logic            clk,
  input logic            rst_n,
  game_state_mp_if.slave bus
);
  localparam int unsigned LW = $clog2(LIVES + 1);
  localparam int unsigned HW = $clog2(DEATH_HOLD + 1);
  localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
  localparam logic [HW-1:0] HOLD_INIT  = HW'(DEATH_HOLD);

  typedef enum logic [2:0] {
    StIdle, StInit, StRun, StPause, StDying, StOver
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_PLAYERS-1:0]          mask_q, mask_d;
  logic [NUM_PLAYERS-1:0]          alive_q, alive_d;
  logic [NUM_PLAYERS-1:0][LW-1:0]  lives_q, lives_d;
  logic [HW-1:0]                   hold_q, hold_d;
  logic [NUM_PLAYERS-1:0]          init_q, init_d;
  logic                            black_q, black_d;
  logic                            pause_q, pause_d;
  logic                            over_q, over_d;

  logic                            start_key, pause_key;
  logic [NUM_PLAYERS-1:0]          dead;
  logic [NUM_PLAYERS-1:0]          respawn;

  assign start_key = bus.key_valid && (bus.key_code == KEY_START);
  assign pause_key = bus.key_valid && (bus.key_code == KEY_PAUSE);
  // Players already out of lives can never be charged again.
  assign dead      = bus.died & alive_q;
  // Only players that died and still have lives are reinitialised.
  assign respawn   = mask_q & alive_q;

  // Next-state, lives bookkeeping and output decode.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    alive_d = alive_q;
    lives_d = lives_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (start_key) begin
          mask_d  = '1;
          state_d = StInit;
        end
      end
      StInit: state_d = StRun;
      StRun: begin
        if (dead != '0) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (dead[i]) begin
              lives_d[i] = lives_q[i] - LW'(1);
              if (lives_q[i] == LW'(1)) alive_d[i] = 1'b0;
            end
          end
          mask_d  = dead;
          hold_d  = HOLD_INIT;
          state_d = StDying;
        end else if (pause_key) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (pause_key) state_d = StRun;
      end
      StDying: begin
        if (bus.frame_tick) begin
          if (hold_q != '0) hold_d = hold_q - HW'(1);
          if (hold_q == HW'(1)) begin
            if (alive_q == '0) begin
              state_d = StOver;
            end else begin
              mask_d  = respawn;
              state_d = (respawn == '0) ? StRun : StInit;
            end
          end
        end
      end
      StOver: begin
        if (start_key) begin
          lives_d = {NUM_PLAYERS{LIVES_INIT}};
          alive_d = '1;
          mask_d  = '1;
          state_d = StInit;
        end
      end
      default: state_d = StIdle;
    endcase

    black_d = (state_d == StIdle);
    pause_d = (state_d != StRun);
    over_d  = (state_d == StOver);
    init_d  = (state_d == StInit) ? mask_d : '0;
  end

  // State and registered outputs; reset also kills any pending init pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mask_q  <= '0;
      alive_q <= '1;
      lives_q <= {NUM_PLAYERS{LIVES_INIT}};
      hold_q  <= '0;
      init_q  <= '0;
      black_q <= 1'b1;
      pause_q <= 1'b1;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      alive_q <= alive_d;
      lives_q <= lives_d;
      hold_q  <= hold_d;
      init_q  <= init_d;
      black_q <= black_d;
      pause_q <= pause_d;
      over_q  <= over_d;
    end
  end

  assign bus.init_snake   = init_q;
  assign bus.screen_black = black_q;
  assign bus.screen_pause = pause_q;
  assign bus.game_over    = over_q;
  assign bus.alive        = alive_q;
  assign bus.lives        = lives_q;
endmodule

// File: tb/tb_game_state_mp.sv
// Directed bench for game_state_mp (2 players, 3 lives, 60-frame hold).
// Stimulus pushes expected status and init pulses into queues; a negedge
// monitor pops and compares them.
module tb_game_state_mp;
  localparam int unsigned NP = 2;
  localparam int unsigned LW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  game_state_mp_if #(.NUM_PLAYERS(NP), .LW(LW)) bus ();

  game_state_mp #(
    .NUM_PLAYERS(NP),
    .LIVES      (3),
    .DEATH_HOLD (60),
    .KEY_START  (8'h29),
    .KEY_PAUSE  (8'h4D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    int         at;
    logic [1:0] init;
    logic       black;
    logic       pause;
    logic       over;
    logic [1:0] alive;
    logic [3:0] lives;
  } exp_t;

  exp_t       sq[$];
  logic [1:0] iq[$];

  // Monitor: every init pulse must match a queued mask; status checks at their cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [1:0]  m;
    logic [10:0] got;
    logic [10:0] want;
    if (bus.init_snake != 2'b00) begin
      checks++;
      if (iq.size() == 0) begin
        errors++;
        $display("FAIL init_pulse: got init_snake=%b, required none", bus.init_snake);
      end else begin
        m = iq.pop_front();
        if (bus.init_snake !== m) begin
          errors++;
          $display("FAIL init_pulse: got init_snake=%b, required %b", bus.init_snake, m);
        end
      end
    end
    while (sq.size() > 0 && sq[0].at <= cyc) begin
      e    = sq.pop_front();
      got  = {bus.init_snake, bus.screen_black, bus.screen_pause, bus.game_over,
              bus.alive, bus.lives};
      want = {e.init, e.black, e.pause, e.over, e.alive, e.lives};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s: got init=%b black=%b pause=%b over=%b alive=%b lives=%h, required init=%b black=%b pause=%b over=%b alive=%b lives=%h",
                 e.name, got[10:9], got[8], got[7], got[6], got[5:4], got[3:0],
                 want[10:9], want[8], want[7], want[6], want[5:4], want[3:0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string n, input logic [1:0] i, input logic b,
                           input logic p, input logic o, input logic [1:0] a,
                           input logic [3:0] l);
    exp_t e;
    e.name = n; e.at = cyc; e.init = i; e.black = b; e.pause = p; e.over = o;
    e.alive = a; e.lives = l;
    sq.push_back(e);
  endtask

  task automatic key(input logic [7:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick();
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
  endtask

  task automatic pulse_died(input logic [1:0] m);
    bus.died = m;
    tick();
    bus.died = 2'b00;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      tick();
      bus.frame_tick = 1'b0;
      tick();
      tick();
    end
  endtask

  // Runs the rest of a death hold (done frames already elapsed) and checks the exit.
  task automatic hold_out(input int done, input logic [1:0] init_m, input bit to_over,
                          input logic [1:0] al, input logic [3:0] lv);
    frames(59 - done);
    expect_st("hold_59", 2'b00, 1'b0, 1'b1, 1'b0, al, lv);
    if (init_m != 2'b00) iq.push_back(init_m);
    bus.frame_tick = 1'b1;
    tick();
    bus.frame_tick = 1'b0;
    if (to_over) begin
      expect_st("hold_to_over", 2'b00, 1'b0, 1'b1, 1'b1, al, lv);
    end else if (init_m != 2'b00) begin
      expect_st("respawn_init", init_m, 1'b0, 1'b1, 1'b0, al, lv);
      tick();
      expect_st("run_after_respawn", 2'b00, 1'b0, 1'b0, 1'b0, al, lv);
    end else begin
      expect_st("run_skip_init", 2'b00, 1'b0, 1'b0, 1'b0, al, lv);
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 8'h00;
    bus.died       = 2'b00;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    expect_st("reset", 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 4'hF);
    tick();
    rst_n = 1'b1;
    tick();
    expect_st("idle", 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 4'hF);
    key(8'h1C);
    expect_st("idle_other_key", 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 4'hF);

    iq.push_back(2'b11);
    key(8'h29);
    expect_st("start_init", 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 4'hF);
    tick();
    expect_st("run", 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 4'hF);
    key(8'h1C);
    expect_st("run_other_key", 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 4'hF);

    // Player 0 dies: lives {3,2}; inputs during the hold are dropped.
    pulse_died(2'b01);
    expect_st("death_p0", 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE);
    frames(10);
    pulse_died(2'b10);
    key(8'h4D);
    key(8'h29);
    expect_st("dying_ignores", 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE);
    hold_out(10, 2'b01, 1'b0, 2'b11, 4'hE);

    // Pause ignores deaths and start.
    key(8'h4D);
    expect_st("pause", 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE);
    pulse_died(2'b10);
    key(8'h29);
    expect_st("pause_ignores", 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 4'hE);
    key(8'h4D);
    expect_st("resume", 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 4'hE);

    // Death and pause in the same cycle: death wins.
    bus.died      = 2'b01;
    bus.key_valid = 1'b1;
    bus.key_code  = 8'h4D;
    tick();
    bus.died      = 2'b00;
    bus.key_valid = 1'b0;
    bus.key_code  = 8'h00;
    expect_st("death_beats_pause", 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 4'hD);
    hold_out(0, 2'b01, 1'b0, 2'b11, 4'hD);

    // Player 0 out of lives: no respawn, straight back to RUN.
    pulse_died(2'b01);
    expect_st("p0_out", 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 4'hC);
    hold_out(0, 2'b00, 1'b0, 2'b10, 4'hC);
    pulse_died(2'b01);
    expect_st("dead_p0_ignored", 2'b00, 1'b0, 1'b0, 1'b0, 2'b10, 4'hC);

    // Player 1 loses all lives -> game over.
    pulse_died(2'b10);
    expect_st("p1_death1", 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 4'h8);
    hold_out(0, 2'b10, 1'b0, 2'b10, 4'h8);
    pulse_died(2'b10);
    expect_st("p1_death2", 2'b00, 1'b0, 1'b1, 1'b0, 2'b10, 4'h4);
    hold_out(0, 2'b10, 1'b0, 2'b10, 4'h4);
    pulse_died(2'b10);
    expect_st("p1_death3", 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 4'h0);
    hold_out(0, 2'b00, 1'b1, 2'b00, 4'h0);
    pulse_died(2'b11);
    key(8'h4D);
    expect_st("over_ignores", 2'b00, 1'b0, 1'b1, 1'b1, 2'b00, 4'h0);

    iq.push_back(2'b11);
    key(8'h29);
    expect_st("restart", 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 4'hF);
    tick();
    expect_st("restart_run", 2'b00, 1'b0, 1'b0, 1'b0, 2'b11, 4'hF);

    // Asynchronous reset in the middle of a death hold.
    pulse_died(2'b10);
    expect_st("death_p1_again", 2'b00, 1'b0, 1'b1, 1'b0, 2'b11, 4'hB);
    frames(5);
    #2 rst_n = 1'b0;
    expect_st("async_reset", 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 4'hF);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    expect_st("idle_after_reset", 2'b00, 1'b1, 1'b1, 1'b0, 2'b11, 4'hF);
    iq.push_back(2'b11);
    key(8'h29);
    expect_st("start_after_reset", 2'b11, 1'b0, 1'b1, 1'b0, 2'b11, 4'hF);

    repeat (3) tick();
    checks++;
    if (iq.size() != 0 || sq.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got init=%0d status=%0d pending, required 0",
               iq.size(), sq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
